// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo up/down counter and its prescaler.
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int PRESCALE_W = 16;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Step prescaler: counts enabled cycles 0..PRESCALE-1, tick is combinational on the last one.
// Holds while enable is low; sync_clr returns the phase to 0. No backpressure.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sync_clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;

    assign tick = enable & ~sync_clr & (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with clear, clamped load, wrap/saturate; count and wrap registered (latency 1).
// Optional step prescaler under MOD_COUNTER_PRESCALE_EN. No backpressure: every enabled edge is honoured.
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int               WIDTH    = 12,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int               SATURATE = MODE_WRAP,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tick;

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sync_clr (clear | load),
        .tick     (tick)
    );
`else
    // PRESCALE has no effect without the prescaler.
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable && tick) begin
            // Bounds are tested before the arithmetic so MAX_VAL below 2**WIDTH-1 wraps correctly.
            if (dir == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    if (SATURATE == MODE_WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    if (SATURATE == MODE_WRAP) begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

endmodule
